branch_pc_unit: RTL and testbench
=================================

Name: branch_pc_unit

Overview:
- Next-PC stage that consumes BranchDecide from the branch comparator and owns the architectural program counter.
- Each cycle it selects sequential, branch-target or jump-target PC, and holds the PC on stall.
- On a redirect it emits a one-cycle registered flush for the IF/ID stage.
- Keeps saturating branch statistics for the debug/perf readout.

Parameters:
- WIDTH, 16, PC/data width in bits.
- RESET_VECTOR, 16'h0000, PC value loaded on reset.
- PC_INC, 2, byte increment per 16-bit instruction.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Stall  input  1  hazard unit: hold PC this cycle.
- ResolveValid  input  1  the resolve-stage instruction is valid (not squashed).
- IsBranch  input  1  the resolve-stage instruction is a conditional branch (beq/bne).
- IsJump  input  1  the resolve-stage instruction is an unconditional jump.
- BranchDecide  input  1  from the comparator: 1 = branch condition true.
- ResolvePC  input  WIDTH  PC of the resolve-stage instruction.
- BranchImm  input  8  signed word offset from the branch encoding.
- JumpTarget  input  WIDTH  absolute jump address.
- PC  output  WIDTH  current fetch address (registered).
- FetchValid  output  1  PC is a real fetch (low during reset hold).
- FlushIF  output  1  squash the IF/ID register contents (registered pulse).
- BranchCount  output  16  resolved branches, saturating.
- TakenCount  output  16  taken branches, saturating.

Behaviour:
- Reset is asynchronous, active-high, and overrides everything, including mid-redirect or mid-stall.
  - On reset: PC=RESET_VECTOR, FetchValid=0, FlushIF=0, BranchCount=0, TakenCount=0, state=HOLD.
- FSM states:
  - HOLD: one cycle after reset deassertion. PC is held. Next state RUN; FetchValid goes 1 on entry to RUN.
  - RUN: normal operation.
  - REDIRECT: the single cycle following a redirect. FlushIF=1 in this state only. It returns to RUN unless a new redirect occurs, in which case it stays REDIRECT.
- Redirect conditions (evaluated only in RUN or REDIRECT):
  - Branch taken (Taken) = ResolveValid & IsBranch & BranchDecide.
  - Jump = ResolveValid & IsJump.
  - Redirect = Taken | Jump.
- Next-PC priority, highest first:
  - Jump: PC <= JumpTarget.
  - Taken: PC <= ResolvePC + PC_INC + (sign_extend(BranchImm) << 1), computed modulo 2^WIDTH.
  - Stall: PC held.
  - Otherwise: PC <= PC + PC_INC.
- Redirect beats Stall: the stalled younger instruction is on the wrong path.
- IsBranch and IsJump both high is a control error: Jump wins, and BranchCount is still incremented.
- Redirect latency: the redirect is visible on PC one clock after the resolving cycle. FlushIF is high for that same cycle.
- Wrap-around: PC+PC_INC from 16'hFFFE gives 16'h0000. Target arithmetic wraps silently; no fault is raised.
- Counters:
  - BranchCount increments when ResolveValid & IsBranch.
  - TakenCount increments on Taken.
  - Both saturate at 16'hFFFF and do not wrap.
  - Counters update even when Stall is high.
- During HOLD, all resolve inputs are ignored and the counters are not updated.

Decomposition:
- Shared package (cpu_pkg):
  - WIDTH and PC_INC constants.
  - State encoding: HOLD=2'd0, RUN=2'd1, REDIRECT=2'd2.
  - Next-PC select enum: SEQ, HOLD_PC, BR, JMP.
- One natural sub-module: sat_counter16, instantiated twice for BranchCount and TakenCount.
- The target adder stays inline.

Test Plan:
- Reset release: Reset 1→0, no other inputs.
  - PC stays 16'h0000 for one cycle, then 0002, 0004.
  - FetchValid=0 in HOLD, 1 from RUN onward.
  - FlushIF stays 0.
- Taken branch: ResolvePC=16'h0010, BranchImm=8'hFC (-4), IsBranch=1, BranchDecide=1, ResolveValid=1 for one cycle.
  - Next PC=16'h000A.
  - FlushIF=1 for exactly that cycle.
  - BranchCount=1, TakenCount=1.
- Not-taken branch: same stimulus with BranchDecide=0.
  - PC increments by 2 and FlushIF stays 0.
  - BranchCount increments, TakenCount does not.
- Jump while stalled: IsJump=1, JumpTarget=16'h1234, Stall=1.
  - PC=16'h1234 next cycle and FlushIF=1.
  - Following Stall alone holds PC at 16'h1234.
- Back-to-back redirects plus wrap-around:
  - Taken branch, then a jump on the next cycle: FlushIF stays high for 2 consecutive cycles and the final PC is the jump target.
  - Separately, from PC=16'hFFFE the next sequential PC is 16'h0000.
- Saturation and async reset:
  - Force 65540 taken branches: both counters read 16'hFFFF.
  - Assert Reset mid-REDIRECT between clock edges: immediately PC=0000, FlushIF=0, counters=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants, FSM state and next-PC select encodings
package cpu_pkg;
   localparam int WIDTH = 16;
   localparam int PC_INC = 2;
   localparam logic [15:0] CNT_MAX = 16'hFFFF;
   typedef enum logic [1:0] {HOLD = 2'd0, RUN = 2'd1, REDIRECT = 2'd2} state_t;
   typedef enum logic [1:0] {SEQ, HOLD_PC, BR, JMP} sel_t;
endpackage

// File: rtl/sat_counter16.sv
// sat_counter16: 16-bit event counter that sticks at all-ones
module sat_counter16
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [15:0] count
);
   // count enabled events, never wrapping past the maximum
   always_ff @(posedge clk or posedge rst)
      if (rst) count <= '0;
      else if (en && count != CNT_MAX) count <= count + 16'd1;
endmodule

// File: rtl/branch_pc_unit.sv
// branch_pc_unit: next-PC selection, redirect flush and branch statistics
module branch_pc_unit #(
   parameter int                      WIDTH        = cpu_pkg::WIDTH,
   parameter logic [WIDTH-1:0]        RESET_VECTOR = '0,
   parameter int                      PC_INC       = cpu_pkg::PC_INC
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Stall,
   input  logic             ResolveValid,
   input  logic             IsBranch,
   input  logic             IsJump,
   input  logic             BranchDecide,
   input  logic [WIDTH-1:0] ResolvePC,
   input  logic [7:0]       BranchImm,
   input  logic [WIDTH-1:0] JumpTarget,
   output logic [WIDTH-1:0] PC,
   output logic             FetchValid,
   output logic             FlushIF,
   output logic [15:0]      BranchCount,
   output logic [15:0]      TakenCount
);
   import cpu_pkg::*;
   state_t           state;
   sel_t             sel;
   logic [WIDTH-1:0] br_target;
   logic             active, resolved, taken, jump, redirect;
   assign active   = state != HOLD;
   assign resolved = active & ResolveValid & IsBranch;
   assign taken    = resolved & BranchDecide;
   assign jump     = active & ResolveValid & IsJump;
   assign redirect = taken | jump;
   // jump outranks a taken branch, and any redirect outranks a stall
   always_comb sel = jump ? JMP : taken ? BR : Stall ? HOLD_PC : SEQ;
   // branch target: instruction after the branch plus the word offset in bytes
   always_comb br_target = ResolvePC + WIDTH'(PC_INC) + {{(WIDTH-9){BranchImm[7]}}, BranchImm, 1'b0};
   // state, PC and the registered fetch/flush outputs
   always_ff @(posedge CLK or posedge Reset)
      if (Reset) begin
         state      <= HOLD;
         PC         <= RESET_VECTOR;
         FetchValid <= 1'b0;
         FlushIF    <= 1'b0;
      end else if (state == HOLD) begin
         state      <= RUN;
         FetchValid <= 1'b1;
      end else begin
         state   <= redirect ? REDIRECT : RUN;
         FlushIF <= redirect;
         PC      <= sel == JMP ? JumpTarget : sel == BR ? br_target : sel == HOLD_PC ? PC : PC + WIDTH'(PC_INC);
      end
   sat_counter16 u_branch_cnt (.clk(CLK), .rst(Reset), .en(resolved), .count(BranchCount));
   sat_counter16 u_taken_cnt  (.clk(CLK), .rst(Reset), .en(taken),    .count(TakenCount));
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb_branch_pc_unit: directed and randomized checks against a behavioural next-PC model
module tb_branch_pc_unit;
   logic        CLK = 0, Reset = 1, Stall = 0, ResolveValid = 0, IsBranch = 0, IsJump = 0, BranchDecide = 0;
   logic [15:0] ResolvePC = 0, JumpTarget = 0;
   logic [7:0]  BranchImm = 0;
   logic [15:0] PC, BranchCount, TakenCount;
   logic        FetchValid, FlushIF;
   int n_cmp = 0, n_bad = 0;
   int m_pc, m_bc, m_tc;
   bit m_fv, m_fl, m_hold;

   branch_pc_unit dut (
      .CLK(CLK), .Reset(Reset), .Stall(Stall), .ResolveValid(ResolveValid), .IsBranch(IsBranch),
      .IsJump(IsJump), .BranchDecide(BranchDecide), .ResolvePC(ResolvePC), .BranchImm(BranchImm),
      .JumpTarget(JumpTarget), .PC(PC), .FetchValid(FetchValid), .FlushIF(FlushIF),
      .BranchCount(BranchCount), .TakenCount(TakenCount)
   );

   always #5 CLK = ~CLK;

   task set_in(input bit st, input bit rv, input bit br, input bit jp, input bit bd,
               input logic [15:0] rpc, input logic [7:0] imm, input logic [15:0] jt);
      Stall = st; ResolveValid = rv; IsBranch = br; IsJump = jp; BranchDecide = bd;
      ResolvePC = rpc; BranchImm = imm; JumpTarget = jt;
   endtask

   task model_reset();
      m_pc = 0; m_bc = 0; m_tc = 0; m_fv = 0; m_fl = 0; m_hold = 1;
   endtask

   // advance the model by one clock using the current inputs, then clock the DUT and settle
   task tick();
      bit tk, jp;
      if (m_hold) begin
         m_hold = 0; m_fv = 1; m_fl = 0;
      end else begin
         tk = ResolveValid && IsBranch && BranchDecide;
         jp = ResolveValid && IsJump;
         if (ResolveValid && IsBranch && m_bc < 65535) m_bc++;
         if (tk && m_tc < 65535) m_tc++;
         if (jp) m_pc = JumpTarget;
         else if (tk) m_pc = (int'(ResolvePC) + 2 + 2 * int'($signed(BranchImm))) & 16'hFFFF;
         else if (!Stall) m_pc = (m_pc + 2) & 16'hFFFF;
         m_fl = tk || jp;
      end
      @(posedge CLK); #1;
   endtask

   task apply_reset();
      #3 Reset = 1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #1;
   endtask

   task release_reset();
      @(negedge CLK) Reset = 0;
   endtask

   task test_reset();
      apply_reset();
      n_cmp++; if (PC !== 16'h0000 || FetchValid !== 0 || FlushIF !== 0) begin n_bad++; $display("FAIL reset_outputs got pc=%h fv=%b fl=%b want 0000/0/0", PC, FetchValid, FlushIF); end
      n_cmp++; if (BranchCount !== 0 || TakenCount !== 0) begin n_bad++; $display("FAIL reset_counters got %h/%h want 0/0", BranchCount, TakenCount); end
      release_reset();
      #1;
      n_cmp++; if (FetchValid !== 0) begin n_bad++; $display("FAIL hold_fetchvalid got %b want 0", FetchValid); end
      tick();
      n_cmp++; if (PC !== 16'h0000 || FetchValid !== 1 || FlushIF !== 0) begin n_bad++; $display("FAIL run_entry got pc=%h fv=%b fl=%b want 0000/1/0", PC, FetchValid, FlushIF); end
      tick();
      n_cmp++; if (PC !== 16'h0002) begin n_bad++; $display("FAIL seq_pc1 got %h want 0002", PC); end
      tick();
      n_cmp++; if (PC !== 16'h0004 || FlushIF !== 0) begin n_bad++; $display("FAIL seq_pc2 got pc=%h fl=%b want 0004/0", PC, FlushIF); end
   endtask

   task test_taken();
      set_in(0, 1, 1, 0, 1, 16'h0010, 8'hFC, 0);
      tick();
      n_cmp++; if (PC !== 16'h000A || FlushIF !== 1) begin n_bad++; $display("FAIL taken_pc got pc=%h fl=%b want 000A/1", PC, FlushIF); end
      n_cmp++; if (BranchCount !== 1 || TakenCount !== 1) begin n_bad++; $display("FAIL taken_counts got %0d/%0d want 1/1", BranchCount, TakenCount); end
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      n_cmp++; if (PC !== 16'h000C || FlushIF !== 0) begin n_bad++; $display("FAIL taken_after got pc=%h fl=%b want 000C/0", PC, FlushIF); end
   endtask

   task test_not_taken();
      set_in(0, 1, 1, 0, 0, 16'h0010, 8'hFC, 0);
      tick();
      n_cmp++; if (PC !== 16'h000E || FlushIF !== 0) begin n_bad++; $display("FAIL nottaken_pc got pc=%h fl=%b want 000E/0", PC, FlushIF); end
      n_cmp++; if (BranchCount !== 2 || TakenCount !== 1) begin n_bad++; $display("FAIL nottaken_counts got %0d/%0d want 2/1", BranchCount, TakenCount); end
   endtask

   task test_jump_stall();
      set_in(1, 1, 0, 1, 0, 0, 0, 16'h1234);
      tick();
      n_cmp++; if (PC !== 16'h1234 || FlushIF !== 1) begin n_bad++; $display("FAIL jump_stall got pc=%h fl=%b want 1234/1", PC, FlushIF); end
      set_in(1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      n_cmp++; if (PC !== 16'h1234 || FlushIF !== 0) begin n_bad++; $display("FAIL stall_hold got pc=%h fl=%b want 1234/0", PC, FlushIF); end
      set_in(0, 1, 1, 1, 0, 0, 0, 16'h2000);
      tick();
      n_cmp++; if (PC !== 16'h2000 || BranchCount !== 3 || TakenCount !== 1) begin n_bad++; $display("FAIL both_flags got pc=%h bc=%0d tc=%0d want 2000/3/1", PC, BranchCount, TakenCount); end
   endtask

   task test_back_to_back();
      set_in(0, 1, 1, 0, 1, 16'h0100, 8'h10, 0);
      tick();
      n_cmp++; if (PC !== 16'h0122 || FlushIF !== 1) begin n_bad++; $display("FAIL b2b_first got pc=%h fl=%b want 0122/1", PC, FlushIF); end
      set_in(0, 1, 0, 1, 0, 0, 0, 16'hFFFE);
      tick();
      n_cmp++; if (PC !== 16'hFFFE || FlushIF !== 1) begin n_bad++; $display("FAIL b2b_second got pc=%h fl=%b want FFFE/1", PC, FlushIF); end
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      n_cmp++; if (PC !== 16'h0000 || FlushIF !== 0) begin n_bad++; $display("FAIL wrap got pc=%h fl=%b want 0000/0", PC, FlushIF); end
   endtask

   task test_random();
      for (int i = 0; i < 400; i++) begin
         set_in($urandom_range(0, 9) < 3, $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 4) == 0,
                $urandom_range(0, 1), 16'($urandom) & 16'hFFFE, 8'($urandom), 16'($urandom) & 16'hFFFE);
         tick();
         n_cmp++;
         if ({PC, FetchValid, FlushIF, BranchCount, TakenCount} !== {16'(m_pc), m_fv, m_fl, 16'(m_bc), 16'(m_tc)}) begin
            n_bad++;
            $display("FAIL random[%0d] got pc=%h fv=%b fl=%b bc=%0d tc=%0d want pc=%h fv=%b fl=%b bc=%0d tc=%0d",
                     i, PC, FetchValid, FlushIF, BranchCount, TakenCount, 16'(m_pc), m_fv, m_fl, m_bc, m_tc);
         end
      end
   endtask

   task test_saturation_async_reset();
      apply_reset();
      release_reset();
      tick();
      set_in(0, 1, 1, 0, 1, 16'h0040, 8'h02, 0);
      for (int i = 0; i < 65540; i++) tick();
      n_cmp++; if (BranchCount !== 16'hFFFF || TakenCount !== 16'hFFFF) begin n_bad++; $display("FAIL saturate got %h/%h want FFFF/FFFF", BranchCount, TakenCount); end
      n_cmp++; if (m_bc != 65535 || BranchCount !== 16'(m_bc)) begin n_bad++; $display("FAIL saturate_model got %h want %h", BranchCount, 16'(m_bc)); end
      n_cmp++; if (FlushIF !== 1 || PC !== 16'h0046) begin n_bad++; $display("FAIL pre_reset got pc=%h fl=%b want 0046/1", PC, FlushIF); end
      apply_reset();
      n_cmp++; if (PC !== 16'h0000 || FlushIF !== 0 || FetchValid !== 0) begin n_bad++; $display("FAIL async_reset got pc=%h fl=%b fv=%b want 0000/0/0", PC, FlushIF, FetchValid); end
      n_cmp++; if (BranchCount !== 0 || TakenCount !== 0) begin n_bad++; $display("FAIL async_reset_counts got %h/%h want 0/0", BranchCount, TakenCount); end
      release_reset();
      set_in(0, 1, 1, 0, 1, 16'h0040, 8'h02, 0);
      tick();
      n_cmp++; if (PC !== 16'h0000 || BranchCount !== 0 || FlushIF !== 0) begin n_bad++; $display("FAIL hold_ignores got pc=%h bc=%0d fl=%b want 0000/0/0", PC, BranchCount, FlushIF); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_taken();
      test_not_taken();
      test_jump_stall();
      test_back_to_back();
      test_random();
      test_saturation_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
